aes64_kexp_seq: RTL
===================

AES64_KEXP_SEQ -- requirements
Module: aes64_kexp_seq

Interface
REQ-001 Parameters: none; SHALL be configured only by the macro in Configuration.
REQ-002 clk  in  1  sole clock; all state SHALL update on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 Start  in  1  begin AES-128 key expansion of KeyIn; sampled only in IDLE.
REQ-005 Abort  in  1  synchronous cancel of a run in progress.
REQ-006 Decrypt  in  1  latched with Start; request decryption-form round keys (see Configuration).
REQ-007 KeyIn  in  128  cipher key; FIPS-197 byte 0 at KeyIn[7:0]; k0=KeyIn[63:0], k1=KeyIn[127:64].
REQ-008 DPA, DPB  out  64  operands to shared AES datapath A, B.
REQ-009 DPRound  out  4  datapath round input (rnum).
REQ-010 DPSelect  out  4  datapath ZKNSelect.
REQ-011 DPResult  in  64  datapath result; combinational, valid same cycle as operands.
REQ-012 RKValid  out  1  RoundKey/RKIndex valid.
REQ-013 RKReady  in  1  consumer accepts round key when RKValid&RKReady.
REQ-014 RoundKey  out  128  round key, same packing as KeyIn.
REQ-015 RKIndex  out  4  round key number 0..10.
REQ-016 Busy  out  1  high in every state except IDLE.
REQ-017 Done  out  1  one-cycle pulse after round key 10 is accepted.

Function
REQ-018 States: IDLE, EMIT, KS1, KS2A, KS2B, IM0, IM1 (IM* only with macro).
REQ-019 IDLE: on Start, latch KeyIn into k0/k1, Decrypt, clear index; next state EMIT (round key 0 valid cycle after Start).
REQ-020 EMIT: RKValid=1, RoundKey/RKIndex stable until handshake; on handshake: index==10 -> IDLE with Done=1 that cycle; else KS1.
REQ-021 KS1: DPA={k1,k1 upper unused}=k1, DPRound=index, DPSelect=4'b0010; register DPResult as t.
REQ-022 KS2A: DPA=t, DPB=k0, DPSelect=4'b0011; DPResult -> k0.
REQ-023 KS2B: DPA=new k0, DPB=k1, DPSelect=4'b0011; DPResult -> k1; index increments; next EMIT (or IM0 per Configuration).
REQ-024 Outside KS*/IM* states DPA, DPB, DPRound, DPSelect SHALL be zero.
REQ-025 Throughput with RKReady held high: 4 cycles per key after key 0; Start at cycle 0 -> key 0 at cycle 1, key 10 at cycle 41, Done in cycle 41 (non-decrypt).
REQ-026 Start while Busy SHALL be ignored; RKReady without RKValid SHALL be ignored.
REQ-027 Abort in any non-IDLE state: next state IDLE, no Done, no further RKValid; Abort in IDLE no effect; Abort with handshake in same cycle: handshake counts, Abort still wins the transition.
REQ-028 RKIndex SHALL never exceed 10; index SHALL not wrap.

Reset
REQ-029 reset SHALL force IDLE and zero all outputs and internal registers (k0, k1, t, index, Decrypt latch) next edge.
REQ-030 reset SHALL take priority over Start and Abort; reset mid-run SHALL drop the run with no Done.

Configuration
REQ-031 Macro AES_KEXP_DECKEY_EN.
REQ-032 Defined: when Decrypt latched and index 1..9 after KS2B, sequence IM0 (DPA=k0, DPSelect=4'b1000 -> im_lo) then IM1 (DPA=k1, DPSelect=4'b1000 -> im_hi), then EMIT presents {im_hi,im_lo}; k0/k1 SHALL keep untransformed values; keys 0 and 10 untransformed; 6 cycles per key 1..9.
REQ-033 Undefined: IM states absent, Decrypt port present but ignored, all keys forward form.

Verification
REQ-034 KeyIn=2b7e1516_28aed2a6_abf71588_09cf4f3c (FIPS order), RKReady=1 -> key1 a0fafe1788542cb123a339392a6c7605, key10 d014f9a8c9ee2589e13f0cc8b6630ca6, Done at cycle 41.
REQ-035 KeyIn=000102..0f -> key10 13111d7fe3944a17f307a78b4d2b30c5; RKReady low 5 cycles at key 3 -> RoundKey/RKIndex held stable, no DPSelect activity.
REQ-036 Abort asserted in KS2A of round 4 -> IDLE next cycle, Busy=0, no Done; new Start then yields correct key 0.
REQ-037 Start pulsed during run and reset at cycle 20 -> Start ignored; after reset all outputs 0, state IDLE.
REQ-038 Macro defined, Decrypt=1, FIPS key 2b7e.. -> key1 equals InvMixColumns(a0fafe17...) per word, key10 untransformed; key10 at cycle 59.

Source files
------------

// File: rtl/aes64_kexp_seq.sv
// aes64_kexp_seq: sequential AES-128 key expansion that drives a shared
// 64-bit AES datapath (ks1i / ks2 / im selects) and streams the eleven round
// keys to a consumer over a valid/ready handshake.
// Optional feature macro: AES_KEXP_DECKEY_EN. When it is defined, decryption
// requests get InvMixColumns-form round keys 1..9 for the equivalent inverse
// cipher.
module aes64_kexp_seq (
    input  logic         clk,
    input  logic         reset,
    input  logic         Start,
    input  logic         Abort,
    input  logic         Decrypt,
    input  logic [127:0] KeyIn,
    output logic [63:0]  DPA,
    output logic [63:0]  DPB,
    output logic [3:0]   DPRound,
    output logic [3:0]   DPSelect,
    input  logic [63:0]  DPResult,
    output logic         RKValid,
    input  logic         RKReady,
    output logic [127:0] RoundKey,
    output logic [3:0]   RKIndex,
    output logic         Busy,
    output logic         Done
);

    localparam int unsigned IDX_W = 4;
    localparam int unsigned HALF_W = 64;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(10);
    localparam logic [3:0] SEL_KS1 = 4'b0010;
    localparam logic [3:0] SEL_KS2 = 4'b0011;
`ifdef AES_KEXP_DECKEY_EN
    localparam logic [3:0] SEL_IM  = 4'b1000;
    localparam logic [IDX_W-1:0] LAST_IM_SRC = IDX_W'(8);
`endif

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_EMIT = 3'd1,
        ST_KS1  = 3'd2,
        ST_KS2A = 3'd3,
        ST_KS2B = 3'd4
`ifdef AES_KEXP_DECKEY_EN
        ,
        ST_IM0  = 3'd5,
        ST_IM1  = 3'd6
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [HALF_W-1:0]   k0_q, k0_d;
    logic [HALF_W-1:0]   k1_q, k1_d;
    logic [HALF_W-1:0]   t_q, t_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                dec_q, dec_d;
    logic [127:0]        key_out;

`ifdef AES_KEXP_DECKEY_EN
    logic [HALF_W-1:0]   im_lo_q, im_lo_d;
    logic [HALF_W-1:0]   im_hi_q, im_hi_d;

    // Keys 1..9 of a decryption run are presented in InvMixColumns form.
    always_comb begin
        key_out = {k1_q, k0_q};
        if (dec_q && (idx_q != '0) && (idx_q != LAST_IDX)) begin
            key_out = {im_hi_q, im_lo_q};
        end
    end
`else
    logic unused_dec;
    assign unused_dec = dec_q;

    // Forward-form keys only.
    always_comb begin
        key_out = {k1_q, k0_q};
    end
`endif

    // State and key registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            k0_q    <= '0;
            k1_q    <= '0;
            t_q     <= '0;
            idx_q   <= '0;
            dec_q   <= 1'b0;
`ifdef AES_KEXP_DECKEY_EN
            im_lo_q <= '0;
            im_hi_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            k0_q    <= k0_d;
            k1_q    <= k1_d;
            t_q     <= t_d;
            idx_q   <= idx_d;
            dec_q   <= dec_d;
`ifdef AES_KEXP_DECKEY_EN
            im_lo_q <= im_lo_d;
            im_hi_q <= im_hi_d;
`endif
        end
    end

    // Next-state, datapath operand selection and handshake outputs.
    always_comb begin
        state_d  = state_q;
        k0_d     = k0_q;
        k1_d     = k1_q;
        t_d      = t_q;
        idx_d    = idx_q;
        dec_d    = dec_q;
`ifdef AES_KEXP_DECKEY_EN
        im_lo_d  = im_lo_q;
        im_hi_d  = im_hi_q;
`endif
        DPA      = '0;
        DPB      = '0;
        DPRound  = '0;
        DPSelect = '0;
        RKValid  = 1'b0;
        RoundKey = '0;
        RKIndex  = '0;
        Done     = 1'b0;
        Busy     = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    k0_d    = KeyIn[63:0];
                    k1_d    = KeyIn[127:64];
                    dec_d   = Decrypt;
                    idx_d   = '0;
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                RKValid  = 1'b1;
                RoundKey = key_out;
                RKIndex  = idx_q;
                if (RKReady) begin
                    if (idx_q == LAST_IDX) begin
                        Done    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_KS1;
                    end
                end
            end
            ST_KS1: begin
                DPA      = k1_q;
                DPRound  = idx_q;
                DPSelect = SEL_KS1;
                t_d      = DPResult;
                state_d  = ST_KS2A;
            end
            ST_KS2A: begin
                DPA      = t_q;
                DPB      = k0_q;
                DPSelect = SEL_KS2;
                k0_d     = DPResult;
                state_d  = ST_KS2B;
            end
            ST_KS2B: begin
                DPA      = k0_q;
                DPB      = k1_q;
                DPSelect = SEL_KS2;
                k1_d     = DPResult;
                idx_d    = idx_q + IDX_W'(1);
                state_d  = ST_EMIT;
`ifdef AES_KEXP_DECKEY_EN
                if (dec_q && (idx_q <= LAST_IM_SRC)) begin
                    state_d = ST_IM0;
                end
`endif
            end
`ifdef AES_KEXP_DECKEY_EN
            ST_IM0: begin
                DPA      = k0_q;
                DPSelect = SEL_IM;
                im_lo_d  = DPResult;
                state_d  = ST_IM1;
            end
            ST_IM1: begin
                DPA      = k1_q;
                DPSelect = SEL_IM;
                im_hi_d  = DPResult;
                state_d  = ST_EMIT;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort cancels any run; a handshake in the same cycle still happens.
        if (Abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            Done    = 1'b0;
        end
    end

endmodule
